// File: rtl/mips_pkg.sv
// Purpose : shared types and constants for the MIPS instruction-fetch stage.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: fetch FSM state enum, instruction width, PC increment.
package mips_pkg;

   typedef enum logic {
      FETCH = 1'b0,  // normal fetch; data is used on imem_ready
      DRAIN = 1'b1   // a stale fetch is in flight; its data is thrown away
   } if_state_t;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifid_reg.sv
// Purpose : IF/ID pipeline register with load, hold, bubble and clear.
// Latency : 1 cycle from i_load/i_clear/i_bubble to outputs.
// Backpr. : no load/clear/bubble = hold (stall); clear beats load.
// Ports   : clk, rst (sync, active-high); i_load captures i_instr/i_pc and
//           marks valid; i_bubble drops valid only; i_clear drops valid and
//           zeroes the instruction; o_valid/o_instr/o_pc are the register.
import mips_pkg::*;

module ifid_reg (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_bubble,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [31:0]        i_pc,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [31:0]        o_pc
);

   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [31:0]        r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_clear) begin
         // the PC field is left alone; only the instruction is scrubbed
         r_valid <= 1'b0;
         r_instr <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end else if (i_bubble) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage_ctrl.sv
// Purpose : instruction-fetch control: PC, fetch FSM, IF/ID register, redirect.
// Latency : imem_req combinational; accepted fetch lands in IF/ID next cycle.
// Backpr. : imem_ready=0 inserts a bubble; freeze holds PC and IF/ID.
// Ports   : clk/rst (sync, active-high); pc_src+branch_addr redirect; freeze
//           stall; imem_req/imem_addr/imem_ready/imem_rdata memory side;
//           if_valid/if_instr/if_pc IF/ID; flush pulse; taken_cnt redirects.
import mips_pkg::*;

module if_stage_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pc_src,
   input  logic [31:0]        branch_addr,
   input  logic               freeze,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [31:0]        if_pc,
   output logic               flush,
   output logic [CNT_W-1:0]   taken_cnt
);

   if_state_t        r_state;
   if_state_t        w_state_nxt;
   logic [31:0]      r_pc;
   logic [31:0]      w_pc_nxt;
   logic [31:0]      w_pc_plus;
   logic             w_req_raw;
   logic             w_load;
   logic             w_bubble;
   logic             w_clear;
   logic             r_flush;
   logic [CNT_W-1:0] r_taken_cnt;
   logic             w_unused;

   // redirect targets are word aligned; the low address bits are dropped
   assign w_unused  = ^branch_addr[1:0];

   assign w_pc_plus = r_pc + PC_STEP;   // wraps modulo 2^32
   // DRAIN keeps the request up so the in-flight beat can complete
   assign w_req_raw = (r_state == DRAIN) | ~freeze;
   assign imem_req  = ~rst & w_req_raw;
   assign imem_addr = r_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      w_bubble    = 1'b0;
      w_clear     = 1'b0;
      if (pc_src) begin
         w_pc_nxt = {branch_addr[31:2], 2'b00};
         w_clear  = 1'b1;
         if (r_state == FETCH)
            // only a request the memory has not yet accepted leaves stale data behind
            w_state_nxt = (w_req_raw & ~imem_ready) ? DRAIN : FETCH;
         else
            w_state_nxt = imem_ready ? FETCH : DRAIN;
      end else begin
         case (r_state)
            DRAIN: begin
               w_bubble = 1'b1;
               if (imem_ready)
                  w_state_nxt = FETCH;
            end
            default: begin
               if (!freeze) begin
                  if (imem_ready) begin
                     w_load   = 1'b1;
                     w_pc_nxt = w_pc_plus;
                  end else begin
                     w_bubble = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= FETCH;
         r_pc        <= RESET_PC;
         r_flush     <= 1'b0;
         r_taken_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_flush <= pc_src;
         if (pc_src && (r_taken_cnt != {CNT_W{1'b1}}))
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
   end

   ifid_reg u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_clear  (w_clear),
      .i_instr  (imem_rdata),
      .i_pc     (w_pc_plus),
      .o_valid  (if_valid),
      .o_instr  (if_instr),
      .o_pc     (if_pc)
   );

   assign flush     = r_flush;
   assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Purpose : self-checking bench for if_stage_ctrl.
// Latency : n/a.
// Backpr. : n/a.
module tb_if_stage_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        pc_src;
   logic [31:0] branch_addr;
   logic        freeze;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        flush;
   logic [15:0] taken_cnt;

   if_stage_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_src      (pc_src),
      .branch_addr (branch_addr),
      .freeze      (freeze),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .flush       (flush),
      .taken_cnt   (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // scoreboard of instructions expected to appear in IF/ID
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;
   exp_t sb_q[$];

   // bench-side expectation of the fetch stage
   logic [31:0] m_pc    = RST_PC;
   logic [31:0] m_instr = '0;
   logic [31:0] m_ifpc  = '0;
   bit          m_valid = 1'b0;
   bit          m_drain = 1'b0;
   bit          m_flush = 1'b0;
   logic [15:0] m_cnt   = '0;
   logic [31:0] seq     = 32'hA000_0000;

   task automatic step(input bit r, input bit s, input logic [31:0] a,
                       input bit f, input bit rd, input logic [31:0] data);
      bit m_req;
      @(negedge clk);
      rst = r; pc_src = s; branch_addr = a; freeze = f;
      imem_ready = rd; imem_rdata = data;
      #1;
      m_req = !r && (m_drain || !f);
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      chk("imem_addr", imem_addr, m_pc);
      if (r) begin
         m_pc = RST_PC; m_drain = 0; m_valid = 0; m_instr = '0;
         m_ifpc = '0; m_cnt = '0; m_flush = 0;
      end else begin
         m_flush = s;
         if (s) begin
            m_drain = m_drain ? !rd : (m_req && !rd);
            m_pc    = {a[31:2], 2'b00};
            m_valid = 0;
            m_instr = '0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end else if (m_drain) begin
            if (rd) m_drain = 0;
         end else if (!f) begin
            if (rd) begin
               sb_q.push_back({data, m_pc + 32'd4});
               m_instr = data;
               m_ifpc  = m_pc + 32'd4;
               m_pc    = m_pc + 32'd4;
               m_valid = 1;
            end else begin
               m_valid = 0;
            end
         end
      end
      @(posedge clk);
      #2;
      chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ifpc);
      chk("flush", {31'b0, flush}, {31'b0, m_flush});
      chk("taken_cnt", {16'b0, taken_cnt}, {16'b0, m_cnt});
      chk("pc", imem_addr, m_pc);
   endtask

   task automatic fetch(input int n);
      for (int i = 0; i < n; i++) begin
         seq = seq + 32'd1;
         step(0, 0, 32'h0, 0, 1, seq);
      end
   endtask

   // monitor: each newly presented IF/ID instruction must match the queue head
   bit          prev_valid = 1'b0;
   logic [31:0] prev_instr = '0;
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (if_valid && (!prev_valid || if_instr != prev_instr)) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_instr_q_size", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sb_instr", if_instr, e.instr);
            chk("sb_pc", if_pc, e.pc);
         end
      end
      prev_valid = if_valid;
      prev_instr = if_instr;
   end

   initial begin
      rst = 1; pc_src = 0; branch_addr = '0; freeze = 0;
      imem_ready = 0; imem_rdata = '0;
      step(1, 0, 32'h0, 0, 1, 32'h1111_1111);
      step(1, 1, 32'h40, 1, 1, 32'h2222_2222);

      // straight-line fetch: if_pc 4, 8, 12
      fetch(3);

      // redirect with memory ready; low address bits dropped
      seq = seq + 32'd1;
      step(0, 1, 32'h0000_0103, 0, 1, seq);
      fetch(2);

      // bubble, then redirect while a fetch is outstanding
      step(0, 0, 32'h0, 0, 0, 32'h3333_3333);
      step(0, 1, 32'h0000_0200, 0, 0, 32'h4444_4444);
      step(0, 0, 32'h0, 0, 0, 32'h5555_5555);
      step(0, 0, 32'h0, 0, 0, 32'h6666_6666);
      step(0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
      fetch(1);

      // retarget while draining
      step(0, 1, 32'h0000_0300, 0, 0, 32'h7777_7777);
      step(0, 1, 32'h0000_0400, 0, 0, 32'h8888_8888);
      step(0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
      fetch(1);

      // redirect beats freeze; then freeze alone for 4 cycles
      step(0, 1, 32'h0000_0500, 1, 1, 32'h9999_9999);
      fetch(1);
      for (int i = 0; i < 4; i++) begin
         seq = seq + 32'd1;
         step(0, 0, 32'h0, 1, 1, seq);
      end
      fetch(1);

      // PC wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFFC, 0, 1, 32'hAAAA_AAAA);
      fetch(2);

      // reset in the middle of a drain
      step(0, 1, 32'h0000_0600, 0, 0, 32'hBBBB_BBBB);
      step(1, 1, 32'h0000_0700, 1, 1, 32'hCCCC_CCCC);
      fetch(1);

      // drive the redirect counter to saturation, then one more
      step(1, 0, 32'h0, 0, 1, 32'h0);
      for (int i = 0; i < 65535; i++)
         step(0, 1, 32'h0000_1000, 0, 1, 32'h0);
      step(0, 1, 32'h0000_2000, 0, 1, 32'h0);
      fetch(1);

      @(negedge clk);
      chk("sb_leftover", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
